dcache_ctrl_nb: RTL and testbench

Parametrised, non-blocking data-cache controller for the MAccess stage. It supports configurable line size and address width, and selects write-back/write-allocate or write-through/no-write-allocate at elaboration. It supports one outstanding miss with critical-word-first early restart, hit-under-miss to other lines, and per-word forwarding from the line buffer while the fill is in progress. It sits between the pipeline access port, the cache arrays, the line-fill buffer (LB), the line-write buffer (LW) and the write-through store buffer (WT).

---
 rtl/dcache_ctrl_nb_if.sv | 42 ++++
 rtl/dcache_ctrl_nb.sv | 176 +++++++++++++++++
 tb/tb_dcache_ctrl_nb.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_nb_if.sv
// Pipeline / cache-array / fill / evict / store-buffer signal bundle for dcache_ctrl_nb.
// Latency: none, wires only.
// Backpressure: Stall towards the pipeline, WT_Full from the store buffer.
// Ports: slave = cache controller side, master = pipeline / array / engine side.
interface dcache_ctrl_nb_if #(
  parameter int ADDR_W = 32
);
  logic              En;
  logic              RW;
  logic [ADDR_W-1:0] WordAddress;
  logic              Stall;
  logic              C_Miss;
  logic              C_Dirty;
  logic              R_Enable;
  logic              W_Enable;
  logic              WriteType;
  logic              Merge;
  logic              FromLineBuffer;
  logic              CrtWord;
  logic [ADDR_W-1:0] MissAddress;
  logic              LB_Enable;
  logic              LW_Enable;
  logic              LB_WordValid;
  logic              LB_Completed;
  logic              LW_Completed;
  logic              WT_Enable;
  logic              WT_Full;

  modport slave (
    input  En, RW, WordAddress, C_Miss, C_Dirty,
    input  LB_WordValid, LB_Completed, LW_Completed, WT_Full,
    output Stall, R_Enable, W_Enable, WriteType, Merge, FromLineBuffer, CrtWord,
    output MissAddress, LB_Enable, LW_Enable, WT_Enable
  );

  modport master (
    output En, RW, WordAddress, C_Miss, C_Dirty,
    output LB_WordValid, LB_Completed, LW_Completed, WT_Full,
    input  Stall, R_Enable, W_Enable, WriteType, Merge, FromLineBuffer, CrtWord,
    input  MissAddress, LB_Enable, LW_Enable, WT_Enable
  );
endinterface

// File: rtl/dcache_ctrl_nb.sv
// Non-blocking data-cache controller: one outstanding miss, critical-word-first restart, hit-under-miss.
// Latency: hits combinational; read miss released on first fill beat; write miss released one cycle after fill done.
// Backpressure: Stall on misses, unfilled same-line words, writes during a fill, and WT_Full in write-through mode.
// Ports: Clk, Rst_n (async, active low); bus = dcache_ctrl_nb_if.slave carrying pipeline, array, LB, LW and WT signals.
module dcache_ctrl_nb #(
  parameter int ADDR_W     = 32,
  parameter int LINE_WORDS = 8,
  parameter bit WRITE_BACK = 1'b1
) (
  input logic             Clk,
  input logic             Rst_n,
  dcache_ctrl_nb_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] BEATS = CNT_W'(LINE_WORDS);

  typedef enum logic [2:0] {IDLE, EVICT_FILL, FILL, EARLY, INSTALL, MERGE} state_e;

  state_e                state_q, state_d;
  logic [LINE_WORDS-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_W-1:0]     miss_addr_q, miss_addr_d;
  logic                  is_write_q, is_write_d;
  logic                  evict_q, evict_d;
  logic                  lb_done_q, lb_done_d;
  logic                  lw_done_q, lw_done_d;

  logic [OFF_W-1:0] req_off, crit_off, beat_off;
  logic             same_line, filling, beat_ok, first_beat, fill_done;
  logic             stall, r_en, w_en, wt_en, crt_word, from_lb;

  assign req_off   = bus.WordAddress[OFF_W+1:2];
  assign crit_off  = miss_addr_q[OFF_W+1:2];
  assign same_line = (bus.WordAddress[ADDR_W-1:OFF_W+2] == miss_addr_q[ADDR_W-1:OFF_W+2]);
  assign filling   = (state_q == EVICT_FILL) || (state_q == FILL) || (state_q == EARLY);
  // Beats past the line length are dropped; the sum wraps modulo LINE_WORDS.
  assign beat_ok    = filling && bus.LB_WordValid && (cnt_q != BEATS);
  assign first_beat = beat_ok && (cnt_q == '0);
  assign beat_off   = crit_off + cnt_q[OFF_W-1:0];
  // Completion flags are sticky, but a flag arriving this cycle counts too.
  assign fill_done  = (lb_done_q || bus.LB_Completed) &&
                      (!evict_q || lw_done_q || bus.LW_Completed);

  // Registered state decodes.
  assign bus.LB_Enable   = filling;
  assign bus.LW_Enable   = filling && evict_q;
  assign bus.WriteType   = (state_q == INSTALL) || (state_q == MERGE);
  assign bus.Merge       = (state_q == MERGE);
  assign bus.MissAddress = miss_addr_q;

  // Combinational decodes.
  assign bus.Stall          = stall;
  assign bus.R_Enable       = r_en;
  assign bus.W_Enable       = w_en;
  assign bus.WT_Enable      = wt_en;
  assign bus.CrtWord        = crt_word;
  assign bus.FromLineBuffer = from_lb;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    miss_addr_d = miss_addr_q;
    is_write_d  = is_write_q;
    evict_d     = evict_q;
    lb_done_d   = lb_done_q || (filling && bus.LB_Completed);
    lw_done_d   = lw_done_q || (filling && bus.LW_Completed);
    stall       = 1'b0;
    r_en        = 1'b0;
    w_en        = 1'b0;
    wt_en       = 1'b0;
    crt_word    = 1'b0;
    from_lb     = 1'b0;

    // Mask is registered: a word landing now is forwardable next cycle.
    if (beat_ok) begin
      mask_d[beat_off] = 1'b1;
      cnt_d            = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.En) begin
          if (!bus.C_Miss) begin
            if (!bus.RW) begin
              r_en = 1'b1;
            end else if (WRITE_BACK) begin
              w_en = 1'b1;
            end else if (bus.WT_Full) begin
              stall = 1'b1;
            end else begin
              w_en  = 1'b1;
              wt_en = 1'b1;
            end
          end else if (bus.RW && !WRITE_BACK) begin
            // No-write-allocate: the store goes straight to the store buffer.
            if (bus.WT_Full) stall = 1'b1;
            else             wt_en = 1'b1;
          end else begin
            stall       = 1'b1;
            miss_addr_d = bus.WordAddress;
            mask_d      = '0;
            cnt_d       = '0;
            is_write_d  = bus.RW;
            evict_d     = WRITE_BACK && bus.C_Dirty;
            lb_done_d   = 1'b0;
            lw_done_d   = 1'b0;
            state_d     = (WRITE_BACK && bus.C_Dirty) ? EVICT_FILL : FILL;
          end
        end
      end

      EVICT_FILL, FILL: begin
        stall = 1'b1;
        // Early restart: the critical word is handed over straight from the fill bus.
        if (first_beat && !is_write_q) begin
          crt_word = 1'b1;
          stall    = 1'b0;
          state_d  = EARLY;
        end
        if (fill_done) state_d = is_write_q ? MERGE : INSTALL;
      end

      EARLY: begin
        if (bus.En) begin
          if (bus.RW) begin
            stall = 1'b1;
          end else if (same_line) begin
            // The miss line is not in the arrays yet, so ignore C_Miss here.
            if (mask_q[req_off]) from_lb = 1'b1;
            else                 stall   = 1'b1;
          end else if (bus.C_Miss) begin
            stall = 1'b1;
          end else begin
            r_en = 1'b1;
          end
        end
        if (fill_done) state_d = is_write_q ? MERGE : INSTALL;
      end

      INSTALL: begin
        stall   = bus.En;
        state_d = IDLE;
      end

      MERGE: begin
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      miss_addr_q <= '0;
      is_write_q  <= 1'b0;
      evict_q     <= 1'b0;
      lb_done_q   <= 1'b0;
      lw_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
      is_write_q  <= is_write_d;
      evict_q     <= evict_d;
      lb_done_q   <= lb_done_d;
      lw_done_q   <= lw_done_d;
    end
  end
endmodule

// File: tb/tb_dcache_ctrl_nb.sv
// Bench for dcache_ctrl_nb: one write-back and one write-through instance.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 3 ns after it.
// Backpressure: Stall, WT_Full and the fill/evict strobes are all driven from the bench.
module tb_dcache_ctrl_nb;
  localparam int ADDR_W = 32;
  localparam int LWORDS = 8;

  // Output bundle bit positions.
  localparam logic [9:0] O_STALL = 10'h200;
  localparam logic [9:0] O_REN   = 10'h100;
  localparam logic [9:0] O_WEN   = 10'h080;
  localparam logic [9:0] O_WT    = 10'h040;
  localparam logic [9:0] O_CRT   = 10'h020;
  localparam logic [9:0] O_FB    = 10'h010;
  localparam logic [9:0] O_LB    = 10'h008;
  localparam logic [9:0] O_LW    = 10'h004;
  localparam logic [9:0] O_WTYPE = 10'h002;
  localparam logic [9:0] O_MERGE = 10'h001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_ctrl_nb_if #(.ADDR_W(ADDR_W)) wb_if ();
  dcache_ctrl_nb_if #(.ADDR_W(ADDR_W)) wt_if ();

  dcache_ctrl_nb #(.ADDR_W(ADDR_W), .LINE_WORDS(LWORDS), .WRITE_BACK(1'b1)) u_wb (
    .Clk(clk), .Rst_n(rst_n), .bus(wb_if.slave));
  dcache_ctrl_nb #(.ADDR_W(ADDR_W), .LINE_WORDS(LWORDS), .WRITE_BACK(1'b0)) u_wt (
    .Clk(clk), .Rst_n(rst_n), .bus(wt_if.slave));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    bit          inst;   // 0 = write-back instance, 1 = write-through instance
    bit          en;
    bit          rw;
    logic [31:0] addr;
    bit          miss;
    bit          dirty;
    bit          full;
    logic [9:0]  exp;
  } vec_t;
  vec_t vecs[$];

  // Reference model state (write-back instance, random phase).
  int       m_busy;   // 0 no miss, 1 miss outstanding, 2 line install, 3 store merge
  bit       m_rel, m_wr, m_ev, m_lbs, m_lws;
  int       m_line, m_crit, m_beats;
  bit [7:0] m_have;
  int       e_beats;
  bit       e_lbc, e_lwc;
  bit       s_en, s_rw, s_miss, s_dirty, s_lbv, s_lbc, s_lwc;
  int       s_li, s_off, s_line;
  logic [31:0] s_a;
  logic [9:0]  s_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs_wb();
    return {wb_if.Stall, wb_if.R_Enable, wb_if.W_Enable, wb_if.WT_Enable, wb_if.CrtWord,
            wb_if.FromLineBuffer, wb_if.LB_Enable, wb_if.LW_Enable, wb_if.WriteType, wb_if.Merge};
  endfunction

  function automatic logic [9:0] outs_wt();
    return {wt_if.Stall, wt_if.R_Enable, wt_if.W_Enable, wt_if.WT_Enable, wt_if.CrtWord,
            wt_if.FromLineBuffer, wt_if.LB_Enable, wt_if.LW_Enable, wt_if.WriteType, wt_if.Merge};
  endfunction

  function automatic vec_t mk(input string name, input bit inst, input bit en, input bit rw,
                              input logic [31:0] addr, input bit miss, input bit dirty,
                              input bit full, input logic [9:0] exp);
    vec_t v;
    v.name = name; v.inst = inst; v.en = en; v.rw = rw; v.addr = addr;
    v.miss = miss; v.dirty = dirty; v.full = full; v.exp = exp;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clr_in();
    wb_if.En = 0; wb_if.RW = 0; wb_if.WordAddress = '0; wb_if.C_Miss = 0; wb_if.C_Dirty = 0;
    wb_if.LB_WordValid = 0; wb_if.LB_Completed = 0; wb_if.LW_Completed = 0; wb_if.WT_Full = 0;
    wt_if.En = 0; wt_if.RW = 0; wt_if.WordAddress = '0; wt_if.C_Miss = 0; wt_if.C_Dirty = 0;
    wt_if.LB_WordValid = 0; wt_if.LB_Completed = 0; wt_if.LW_Completed = 0; wt_if.WT_Full = 0;
  endtask

  task automatic wb_in(input bit en, input bit rw, input logic [31:0] a, input bit miss,
                       input bit dirty, input bit lbv, input bit lbc, input bit lwc);
    wb_if.En = en; wb_if.RW = rw; wb_if.WordAddress = a; wb_if.C_Miss = miss;
    wb_if.C_Dirty = dirty; wb_if.LB_WordValid = lbv; wb_if.LB_Completed = lbc;
    wb_if.LW_Completed = lwc; wb_if.WT_Full = 0;
  endtask

  task automatic wt_in(input bit en, input bit rw, input logic [31:0] a, input bit miss,
                       input bit dirty, input bit full, input bit lbv, input bit lbc);
    wt_if.En = en; wt_if.RW = rw; wt_if.WordAddress = a; wt_if.C_Miss = miss;
    wt_if.C_Dirty = dirty; wt_if.WT_Full = full; wt_if.LB_WordValid = lbv;
    wt_if.LB_Completed = lbc; wt_if.LW_Completed = 0;
  endtask

  initial begin
    vecs.push_back(mk("wb_rd_hit",       0, 1, 0, 32'h40,  0, 0, 0, O_REN));
    vecs.push_back(mk("wb_wr_hit",       0, 1, 1, 32'h44,  0, 0, 0, O_WEN));
    vecs.push_back(mk("wb_no_en",        0, 0, 0, 32'h40,  1, 1, 0, 10'h0));
    vecs.push_back(mk("wb_rd_hit_dirty", 0, 1, 0, 32'h48,  0, 1, 0, O_REN));
    vecs.push_back(mk("wt_wr_full1",     1, 1, 1, 32'h80,  0, 0, 1, O_STALL));
    vecs.push_back(mk("wt_wr_full2",     1, 1, 1, 32'h80,  0, 0, 1, O_STALL));
    vecs.push_back(mk("wt_wr_hit",       1, 1, 1, 32'h80,  0, 0, 0, O_WEN | O_WT));
    vecs.push_back(mk("wt_wr_miss",      1, 1, 1, 32'h900, 1, 1, 0, O_WT));
    vecs.push_back(mk("wt_wr_miss_full", 1, 1, 1, 32'h900, 1, 0, 1, O_STALL));
    vecs.push_back(mk("wt_rd_hit",       1, 1, 0, 32'h84,  0, 0, 1, O_REN));
    vecs.push_back(mk("wt_wr_miss2",     1, 1, 1, 32'h904, 1, 0, 0, O_WT));

    // Reset state.
    clr_in();
    #3;
    chk("rst_wb_outs", outs_wb(), 10'h0);
    chk("rst_wt_outs", outs_wt(), 10'h0);
    chk("rst_wb_missaddr", wb_if.MissAddress, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Single-cycle IDLE decodes.
    foreach (vecs[i]) begin
      tick();
      clr_in();
      if (vecs[i].inst) wt_in(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].miss, vecs[i].dirty, vecs[i].full, 0, 0);
      else              wb_in(vecs[i].en, vecs[i].rw, vecs[i].addr, vecs[i].miss, vecs[i].dirty, 0, 0, 0);
      settle();
      chk(vecs[i].name, vecs[i].inst ? outs_wt() : outs_wb(), vecs[i].exp);
    end
    tick(); clr_in(); settle();
    chk("wt_wr_miss_no_fill", outs_wt(), 10'h0);

    // Clean read miss at 0x10C, critical offset 3.
    tick(); wb_in(1, 0, 32'h10C, 1, 0, 0, 0, 0); settle();
    chk("rmiss_stall", outs_wb(), O_STALL);
    tick(); settle();
    chk("rmiss_lb_req", outs_wb(), O_STALL | O_LB);
    chk("rmiss_addr", wb_if.MissAddress, 32'h10C);
    tick(); wb_in(1, 0, 32'h10C, 1, 0, 1, 0, 0); settle();
    chk("rmiss_crtword", outs_wb(), O_CRT | O_LB);
    for (int b = 1; b <= 5; b++) begin
      tick(); wb_in(0, 0, 32'h0, 0, 0, 1, 0, 0); settle();
      chk("early_beat", outs_wb(), O_LB);
    end
    tick(); wb_in(1, 0, 32'h200, 0, 0, 0, 0, 0); settle();
    chk("early_hit_other", outs_wb(), O_REN | O_LB);
    tick(); wb_in(1, 0, 32'h300, 1, 0, 0, 0, 0); settle();
    chk("early_second_miss", outs_wb(), O_STALL | O_LB);
    tick(); wb_in(1, 1, 32'h108, 1, 0, 0, 0, 0); settle();
    chk("early_write", outs_wb(), O_STALL | O_LB);
    tick(); wb_in(1, 0, 32'h10C, 1, 0, 0, 0, 0); settle();
    chk("early_fwd_crit", outs_wb(), O_FB | O_LB);
    tick(); wb_in(1, 0, 32'h104, 1, 0, 1, 0, 0); settle();
    chk("early_same_cycle_word", outs_wb(), O_STALL | O_LB);
    tick(); wb_in(1, 0, 32'h104, 1, 0, 0, 0, 0); settle();
    chk("early_fwd_0x104", outs_wb(), O_FB | O_LB);
    tick(); wb_in(1, 0, 32'h108, 1, 0, 1, 0, 0); settle();
    chk("early_unfilled", outs_wb(), O_STALL | O_LB);
    tick(); wb_in(0, 0, 32'h0, 0, 0, 0, 1, 0); settle();
    chk("early_lb_done", outs_wb(), O_LB);
    tick(); wb_in(1, 0, 32'h40, 0, 0, 0, 0, 0); settle();
    chk("install", outs_wb(), O_STALL | O_WTYPE);
    tick(); wb_in(0, 0, 32'h0, 0, 0, 0, 0, 0); settle();
    chk("install_done", outs_wb(), 10'h0);

    // Dirty write miss, evict completes 3 cycles before the fill.
    tick(); wb_in(1, 1, 32'h208, 1, 1, 0, 0, 0); settle();
    chk("wmiss_stall", outs_wb(), O_STALL);
    tick(); settle();
    chk("wmiss_lb_lw", outs_wb(), O_STALL | O_LB | O_LW);
    for (int b = 0; b < 8; b++) begin
      tick(); wb_in(1, 1, 32'h208, 1, 1, 1, 0, 0); settle();
      chk("wmiss_beat", outs_wb(), O_STALL | O_LB | O_LW);
    end
    tick(); wb_in(1, 1, 32'h208, 1, 1, 0, 0, 1); settle();
    chk("wmiss_lw_done", outs_wb(), O_STALL | O_LB | O_LW);
    for (int k = 0; k < 2; k++) begin
      tick(); wb_in(1, 1, 32'h208, 1, 1, 0, 0, 0); settle();
      chk("wmiss_wait_lb", outs_wb() & O_STALL, O_STALL);
    end
    tick(); wb_in(1, 1, 32'h208, 1, 1, 0, 1, 0); settle();
    chk("wmiss_lb_done", outs_wb() & O_STALL, O_STALL);
    tick(); settle();
    chk("merge", outs_wb() & ~O_STALL, O_WTYPE | O_MERGE);
    tick(); wb_in(0, 0, 32'h0, 0, 0, 0, 0, 0); settle();
    chk("merge_done", outs_wb(), 10'h0);

    // Dirty read miss, fill and evict complete together.
    tick(); wb_in(1, 0, 32'h400, 1, 1, 0, 0, 0); settle();
    chk("drmiss_stall", outs_wb(), O_STALL);
    tick(); settle();
    chk("drmiss_lb_lw", outs_wb(), O_STALL | O_LB | O_LW);
    tick(); wb_in(1, 0, 32'h400, 1, 1, 1, 0, 0); settle();
    chk("drmiss_crtword", outs_wb(), O_CRT | O_LB | O_LW);
    for (int b = 1; b < 8; b++) begin
      tick(); wb_in(0, 0, 32'h0, 0, 0, 1, 0, 0); settle();
    end
    tick(); wb_in(0, 0, 32'h0, 0, 0, 0, 1, 1); settle();
    chk("drmiss_both_done", outs_wb(), O_LB | O_LW);
    tick(); wb_in(0, 0, 32'h0, 0, 0, 0, 0, 0); settle();
    chk("drmiss_install", outs_wb(), O_WTYPE);
    tick(); settle();
    chk("drmiss_idle", outs_wb(), 10'h0);

    // Write-through: dirty read miss never evicts.
    tick(); wt_in(1, 0, 32'h600, 1, 1, 0, 0, 0); settle();
    chk("wt_rmiss_stall", outs_wt(), O_STALL);
    tick(); settle();
    chk("wt_rmiss_no_lw", outs_wt(), O_STALL | O_LB);
    tick(); wt_in(1, 0, 32'h600, 1, 1, 0, 1, 1); settle();
    chk("wt_rmiss_crt", outs_wt(), O_CRT | O_LB);
    tick(); wt_in(0, 0, 32'h0, 0, 0, 0, 0, 0); settle();
    chk("wt_install", outs_wt(), O_WTYPE);
    tick(); settle();
    chk("wt_idle", outs_wt(), 10'h0);

    // Reset dropped during the fill at beat 4.
    tick(); wb_in(1, 0, 32'h500, 1, 0, 0, 0, 0); settle();
    tick(); settle();
    chk("rstfill_lb", outs_wb(), O_STALL | O_LB);
    for (int b = 0; b < 4; b++) begin
      tick(); wb_in(b == 0, 0, 32'h500, 1, 0, 1, 0, 0); settle();
    end
    tick(); wb_in(0, 0, 32'h0, 0, 0, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("rstfill_outs", outs_wb(), 10'h0);
    chk("rstfill_missaddr", wb_if.MissAddress, 32'h0);
    clr_in();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick(); wb_in(0, 0, 32'h0, 0, 0, 1, k == 4, k == 4); settle();
      chk("stray_beat", outs_wb(), 10'h0);
    end
    tick(); wb_in(1, 0, 32'h504, 0, 0, 0, 0, 0); settle();
    chk("post_rst_hit", outs_wb(), O_REN);

    // Random traffic against the reference model.
    m_busy = 0; m_rel = 0; m_wr = 0; m_ev = 0; m_lbs = 0; m_lws = 0;
    m_line = 0; m_crit = 0; m_beats = 0; m_have = '0;
    e_beats = 0; e_lbc = 0; e_lwc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      clr_in();
      s_en    = ($urandom_range(3) != 0);
      s_rw    = 1'($urandom_range(1));
      s_li    = int'($urandom_range(3));
      s_off   = int'($urandom_range(7));
      s_a     = 32'h100 + 32'(s_li * 32) + 32'(s_off * 4);
      s_line  = int'(s_a >> 5);
      s_miss  = ($urandom_range(2) == 0);
      s_dirty = 1'($urandom_range(1));
      s_lbv = 0; s_lbc = 0; s_lwc = 0;
      if (m_busy == 1) begin
        if (e_beats < 10 && $urandom_range(1) == 1) begin
          s_lbv = 1; e_beats++;
        end else if (e_beats >= 8 && !e_lbc && $urandom_range(2) == 0) begin
          s_lbc = 1; e_lbc = 1;
        end
        if (m_ev && !e_lwc && $urandom_range(4) == 0) begin
          s_lwc = 1; e_lwc = 1;
        end
      end else if ($urandom_range(15) == 0) begin
        s_lbv = 1; s_lbc = 1'($urandom_range(1)); s_lwc = 1'($urandom_range(1));
      end
      wb_in(s_en, s_rw, s_a, s_miss, s_dirty, s_lbv, s_lbc, s_lwc);
      settle();

      s_exp = '0;
      case (m_busy)
        0: if (s_en) s_exp = s_miss ? O_STALL : (s_rw ? O_WEN : O_REN);
        1: begin
          s_exp = O_LB | (m_ev ? O_LW : 10'h0);
          if (!m_rel) begin
            if (!m_wr && s_lbv && m_beats == 0) s_exp |= O_CRT;
            else                                s_exp |= O_STALL;
          end else if (s_en) begin
            if (!s_rw && s_line == m_line) s_exp |= m_have[s_off] ? O_FB : O_STALL;
            else if (!s_rw && !s_miss)      s_exp |= O_REN;
            else                            s_exp |= O_STALL;
          end
        end
        2: s_exp = O_WTYPE | (s_en ? O_STALL : 10'h0);
        default: s_exp = O_WTYPE | O_MERGE;
      endcase
      if (m_busy == 3) chk("rand", outs_wb() & ~O_STALL, s_exp);
      else             chk("rand", outs_wb(), s_exp);

      case (m_busy)
        0: if (s_en && s_miss) begin
          m_busy = 1; m_line = s_line; m_crit = s_off; m_wr = s_rw; m_ev = s_dirty;
          m_beats = 0; m_have = '0; m_lbs = 0; m_lws = 0; m_rel = 0;
          e_beats = 0; e_lbc = 0; e_lwc = 0;
        end
        1: begin
          if (s_lbv && m_beats < LWORDS) begin
            m_have[(m_crit + m_beats) % LWORDS] = 1'b1;
            if (m_beats == 0 && !m_wr) m_rel = 1;
            m_beats++;
          end
          m_lbs = m_lbs | s_lbc;
          m_lws = m_lws | s_lwc;
          if (m_lbs && (!m_ev || m_lws)) m_busy = m_wr ? 3 : 2;
        end
        default: m_busy = 0;
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
